// File: rtl/uart_tx_sched.sv
// Drives a UART through a TL-UL host port: one CTRL write at start-up, then a
// STATUS poll followed by a WDATA write for each byte offered by the requester.
`timescale 1ns/1ps
module uart_tx_sched #(
    parameter logic [15:0] NcoVal     = 16'd1024,
    parameter logic [31:0] CtrlAddr   = 32'h10,
    parameter logic [31:0] StatusAddr = 32'h14,
    parameter logic [31:0] WdataAddr  = 32'h1C,
    parameter logic [7:0]  SrcId      = 8'h5A,
    parameter int unsigned PollGap    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        tl_a_valid_o,
    output logic [2:0]  tl_a_opcode_o,
    output logic [1:0]  tl_a_size_o,
    output logic [3:0]  tl_a_mask_o,
    output logic [31:0] tl_a_address_o,
    output logic [31:0] tl_a_data_o,
    output logic [7:0]  tl_a_source_o,
    output logic [2:0]  tl_a_param_o,
    output logic        tl_d_ready_o,
    input  logic        tl_a_ready_i,
    input  logic        tl_d_valid_i,
    input  logic [2:0]  tl_d_opcode_i,
    input  logic [31:0] tl_d_data_i,
    input  logic [7:0]  tl_d_source_i,
    input  logic        tl_d_error_i,
    output logic        init_done_o,
    output logic        err_o
);

    localparam logic [2:0]  OpPut     = 3'd0;
    localparam logic [2:0]  OpGet     = 3'd4;
    localparam logic [2:0]  OpAck     = 3'd0;
    localparam logic [2:0]  OpAckData = 3'd1;
    localparam logic [31:0] CtrlWord  = {NcoVal, 15'b0, 1'b1};
    localparam logic [15:0] GapLoad   = 16'(PollGap);

    typedef enum logic [2:0] {
        INIT_A, INIT_D, IDLE, GAP, POLL_A, POLL_D, WR_A, WR_D
    } state_e;

    state_e      r_state;
    logic        r_a_valid;
    logic [2:0]  r_a_opcode;
    logic [31:0] r_a_address;
    logic [31:0] r_a_data;
    logic        r_byte_ready;
    logic        r_init_done;
    logic        r_err;
    logic [7:0]  r_byte;
    logic [15:0] r_gap_cnt;

    logic        w_in_d;
    logic [2:0]  w_exp_opcode;
    logic        w_resp_err;
    logic        w_unused_data;

    assign w_in_d        = (r_state == INIT_D) || (r_state == POLL_D) || (r_state == WR_D);
    assign w_exp_opcode  = (r_state == POLL_D) ? OpAckData : OpAck;
    assign w_resp_err    = tl_d_error_i || (tl_d_source_i != SrcId) ||
                           (tl_d_opcode_i != w_exp_opcode);
    assign w_unused_data = ^tl_d_data_i[31:1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= INIT_A;
            r_a_valid    <= 1'b0;
            r_a_opcode   <= OpPut;
            r_a_address  <= '0;
            r_a_data     <= '0;
            r_byte_ready <= 1'b0;
            r_init_done  <= 1'b0;
            r_err        <= 1'b0;
            r_byte       <= '0;
            r_gap_cnt    <= '0;
        end else begin
            // Stray responses and malformed acks both latch the sticky error.
            if (tl_d_valid_i && (!w_in_d || w_resp_err)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                INIT_A: begin
                    if (!r_a_valid) begin
                        r_a_valid   <= 1'b1;
                        r_a_opcode  <= OpPut;
                        r_a_address <= CtrlAddr;
                        r_a_data    <= CtrlWord;
                    end else if (tl_a_ready_i) begin
                        r_a_valid <= 1'b0;
                        r_state   <= INIT_D;
                    end
                end
                INIT_D: begin
                    if (tl_d_valid_i) begin
                        if (w_resp_err) begin
                            r_a_valid   <= 1'b1;
                            r_a_opcode  <= OpPut;
                            r_a_address <= CtrlAddr;
                            r_a_data    <= CtrlWord;
                            r_state     <= INIT_A;
                        end else begin
                            r_init_done  <= 1'b1;
                            r_byte_ready <= 1'b1;
                            r_state      <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (byte_valid_i && r_byte_ready) begin
                        r_byte       <= byte_data_i;
                        r_byte_ready <= 1'b0;
                        r_a_valid    <= 1'b1;
                        r_a_opcode   <= OpGet;
                        r_a_address  <= StatusAddr;
                        r_a_data     <= '0;
                        r_state      <= POLL_A;
                    end
                end
                GAP: begin
                    if (r_gap_cnt <= 16'd1) begin
                        r_gap_cnt   <= '0;
                        r_a_valid   <= 1'b1;
                        r_a_opcode  <= OpGet;
                        r_a_address <= StatusAddr;
                        r_a_data    <= '0;
                        r_state     <= POLL_A;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                    end
                end
                POLL_A: begin
                    if (tl_a_ready_i) begin
                        r_a_valid <= 1'b0;
                        r_state   <= POLL_D;
                    end
                end
                POLL_D: begin
                    if (tl_d_valid_i) begin
                        if (w_resp_err) begin
                            r_byte_ready <= 1'b1;
                            r_state      <= IDLE;
                        end else if (tl_d_data_i[0]) begin
                            // TX FIFO full: back off before polling again.
                            if (PollGap == 0) begin
                                r_a_valid   <= 1'b1;
                                r_a_opcode  <= OpGet;
                                r_a_address <= StatusAddr;
                                r_a_data    <= '0;
                                r_state     <= POLL_A;
                            end else begin
                                r_gap_cnt <= GapLoad;
                                r_state   <= GAP;
                            end
                        end else begin
                            r_a_valid   <= 1'b1;
                            r_a_opcode  <= OpPut;
                            r_a_address <= WdataAddr;
                            r_a_data    <= {24'b0, r_byte};
                            r_state     <= WR_A;
                        end
                    end
                end
                WR_A: begin
                    if (tl_a_ready_i) begin
                        r_a_valid <= 1'b0;
                        r_state   <= WR_D;
                    end
                end
                WR_D: begin
                    if (tl_d_valid_i) begin
                        r_byte_ready <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= INIT_A;
            endcase
        end
    end

    assign byte_ready_o   = r_byte_ready;
    assign tl_a_valid_o   = r_a_valid;
    assign tl_a_opcode_o  = r_a_opcode;
    assign tl_a_size_o    = 2'b10;
    assign tl_a_mask_o    = 4'hF;
    assign tl_a_address_o = r_a_address;
    assign tl_a_data_o    = r_a_data;
    assign tl_a_source_o  = SrcId;
    assign tl_a_param_o   = 3'b000;
    assign tl_d_ready_o   = 1'b1;
    assign init_done_o    = r_init_done;
    assign err_o          = r_err;

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NcoVal, 16'd1024, baud NCO written to CTRL[31:16].
- CtrlAddr, 32'h10, UART CTRL offset.
- StatusAddr, 32'h14, UART STATUS offset.
- WdataAddr, 32'h1C, UART WDATA offset.
- SrcId, 8'h5A, a_source for all requests.
- PollGap, 4, idle cycles between STATUS polls.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset.
- byte_valid_i, in, 1, requester byte valid.
- byte_data_i, in, 8, requester byte.
- byte_ready_o, out, 1, byte accepted this cycle.
- tl_a_valid_o, out, 1, TL-UL A valid.
- tl_a_opcode_o, out, 3, 0=PutFullData, 4=Get.
- tl_a_size_o, out, 2, always 2'b10.
- tl_a_mask_o, out, 4, always 4'hF.
- tl_a_address_o, out, 32, target offset.
- tl_a_data_o, out, 32, write data.
- tl_a_source_o, out, 8, always SrcId.
- tl_a_param_o, out, 3, always 3'b000.
- tl_d_ready_o, out, 1, always 1.
- tl_a_ready_i, in, 1, device A ready.
- tl_d_valid_i, in, 1, response valid.
- tl_d_opcode_i, in, 3, 0=AccessAck, 1=AccessAckData.
- tl_d_data_i, in, 32, read data.
- tl_d_source_i, in, 8, response source.
- tl_d_error_i, in, 1, response error.
- init_done_o, out, 1, CTRL write completed.
- err_o, out, 1, sticky error flag.
REQ-003 Single clock clk_i; reset rst_ni SHALL be asynchronous, active-low.

Function
REQ-004 States SHALL be: INIT_A, INIT_D, IDLE, GAP, POLL_A, POLL_D, WR_A, WR_D.
REQ-005 Leaving reset, FSM SHALL enter INIT_A and issue PutFullData to CtrlAddr with data {NcoVal,15'b0,1'b1} (TX enable).
REQ-006 Each *_A state SHALL hold tl_a_valid_o=1 with stable fields until tl_a_ready_i=1, then advance to the matching *_D state.
REQ-007 Each *_D state SHALL have tl_a_valid_o=0 and wait for tl_d_valid_i; at most one transaction is outstanding.
REQ-008 INIT_D on response: init_done_o SHALL rise next cycle and remain 1 until reset; the FSM SHALL go to IDLE.
REQ-009 IDLE: byte_ready_o SHALL be 1 only in IDLE with init_done_o=1; on byte_valid_i&byte_ready_o the byte SHALL be latched and the FSM SHALL go to POLL_A.
REQ-010 POLL_A SHALL issue Get to StatusAddr; POLL_D with STATUS[0] (txfull)=1 SHALL go to GAP, otherwise to WR_A.
REQ-011 GAP SHALL count PollGap cycles (counter reloaded on entry), then go to POLL_A; PollGap=0 means direct to POLL_A.
REQ-012 WR_A SHALL issue PutFullData to WdataAddr with data {24'b0, latched byte}; WR_D on response SHALL go to IDLE.
REQ-013 Response error is tl_d_error_i=1, tl_d_source_i!=SrcId, or an opcode mismatch (AccessAckData expected for Get, AccessAck for Put); on error err_o SHALL set sticky.
REQ-014 Error in INIT_D SHALL return to INIT_A (retry); error in POLL_D or WR_D SHALL drop the byte and go to IDLE.
REQ-015 tl_d_valid_i outside *_D states SHALL be ignored and SHALL set err_o.
REQ-016 A byte is accepted at most once per IDLE visit; byte throughput is therefore one per completed WR_D.

Reset
REQ-017 Under reset: state=INIT_A with A-channel not yet valid, tl_a_valid_o=0, byte_ready_o=0, init_done_o=0, err_o=0, counter=0, latched byte=0.
REQ-018 tl_a_valid_o SHALL first assert on the first clock edge after rst_ni deasserts.
REQ-019 Reset mid-transaction SHALL abandon it immediately; responses after reset release with no request outstanding fall under REQ-015.

Verification
REQ-020 Reset release, a_ready=1, AccessAck one cycle later -> A: Put addr 0x10, data 0x04000001; init_done_o=1 the cycle after the D response.
REQ-021 Byte 0x41 offered, STATUS read 0x0 -> Get 0x14, then Put 0x1C data 0x00000041; byte_ready_o=1 again after WR_D.
REQ-022 STATUS returns 0x1 twice, then 0x0 -> three Gets, each separated by 4 idle cycles; a single WDATA write.
REQ-023 a_ready held low 5 cycles during WR_A -> a_valid and fields stable for all 6 cycles; exactly one Put.
REQ-024 d_error=1 on WR_D -> err_o=1 sticky; byte dropped; next byte proceeds normally.
REQ-025 d_source=0x00 on INIT_D -> err_o=1; CTRL write reissued; init_done_o stays 0 until a clean ack.
